// File: rtl/norm_lzc_shifter.sv
`default_nettype none
// ============================================================================
// Module   : norm_lzc_shifter
// Purpose  : Iterative mantissa normaliser. Left-shifts the loaded mantissa
//            until its MSB is set and counts the positions shifted. The count
//            feeds the exponent subtractor; the shifted mantissa feeds
//            rounding/packing.
// Options  : NORM_COARSE_STEP_EN - adds a 4-bit shift step when the top
//            nibble is zero; results are identical, only latency shrinks.
// Revision : 1.0 - initial release
// ============================================================================
module norm_lzc_shifter #(
  parameter int SW = 26,  // mantissa width, must satisfy SW <= 2**W
  parameter int W  = 5    // shift-count width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [SW-1:0] Data_In,
  output logic          busy,
  output logic          ready,
  output logic [SW-1:0] Data_Out,
  output logic [W-1:0]  Shift_Count,
  output logic          Zero_Flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   m_q, m_d;
  logic [W-1:0]    c_q, c_d;
  logic [SW-1:0]   data_out_q, data_out_d;
  logic [W-1:0]    shift_count_q, shift_count_d;
  logic            zero_flag_q, zero_flag_d;

  // Next-state, working-register and result-capture logic
  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    c_d           = c_q;
    data_out_d    = data_out_q;
    shift_count_d = shift_count_q;
    zero_flag_d   = zero_flag_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          m_d         = Data_In;
          c_d         = '0;
          zero_flag_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (m_q == '0) begin
          // All-zero mantissa: nothing to normalise, count stays at zero
          zero_flag_d   = 1'b1;
          data_out_d    = m_q;
          shift_count_d = c_q;
          state_d       = DONE;
        end else if (m_q[SW-1]) begin
          // Results are captured on entry to DONE so they line up with ready
          data_out_d    = m_q;
          shift_count_d = c_q;
          state_d       = DONE;
        end else begin
`ifdef NORM_COARSE_STEP_EN
          // Top nibble clear and value nonzero implies at least 4 more
          // leading zeros, so the coarse step cannot overshoot the MSB.
          if (m_q[SW-1 -: 4] == 4'd0) begin
            m_d = m_q << 4;
            c_d = c_q + W'(4);
          end else begin
            m_d = m_q << 1;
            c_d = c_q + W'(1);
          end
`else
          m_d = m_q << 1;
          c_d = c_q + W'(1);
`endif
        end
      end
      DONE: begin
        // Single-cycle result pulse; load here is deliberately ignored
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      m_q           <= '0;
      c_q           <= '0;
      data_out_q    <= '0;
      shift_count_q <= '0;
      zero_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      c_q           <= c_d;
      data_out_q    <= data_out_d;
      shift_count_q <= shift_count_d;
      zero_flag_q   <= zero_flag_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign ready       = (state_q == DONE);
  assign Data_Out    = data_out_q;
  assign Shift_Count = shift_count_q;
  assign Zero_Flag   = zero_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_norm_lzc_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_lzc_shifter
// Purpose  : Self-checking bench for norm_lzc_shifter: directed cases plus a
//            random sweep compared against an arithmetic reference model.
//            Honours NORM_COARSE_STEP_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_lzc_shifter;
  localparam int SW = 26;
  localparam int W  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [SW-1:0] data_in;
  logic          busy;
  logic          ready;
  logic [SW-1:0] data_out;
  logic [W-1:0]  shift_count;
  logic          zero_flag;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  norm_lzc_shifter #(.SW(SW), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .Data_In    (data_in),
    .busy       (busy),
    .ready      (ready),
    .Data_Out   (data_out),
    .Shift_Count(shift_count),
    .Zero_Flag  (zero_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leading zeros from the position of the highest set bit
  function automatic int ref_lz(input int unsigned v);
    if (v == 0) return 0;
    return SW - $clog2(v + 1);
  endfunction

  // Cycles spent in SHIFT for a given input
  function automatic int ref_shift_len(input int unsigned v);
    int l;
    if (v == 0) return 1;
    l = ref_lz(v);
`ifdef NORM_COARSE_STEP_EN
    return (l / 4) + (l % 4) + 1;
`else
    return l + 1;
`endif
  endfunction

  // One operation: load, optionally poke an ignored load mid-SHIFT, wait for ready, check
  task automatic run_op(input string tag, input logic [SW-1:0] d, input bit poke_busy);
    int unsigned v;
    int lat;
    int lz;
    v  = int'(d);
    lz = ref_lz(v);
    @(negedge clk);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 1;
    if (poke_busy) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      data_in = 26'h1;
      load    = 1'b1;
      @(negedge clk);
      load = 1'b0;
      lat++;
    end
    while (!ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(ref_shift_len(v) + 1));
    chk({tag, "_data"}, 32'(data_out), (v << lz));
    chk({tag, "_count"}, 32'(shift_count), 32'(lz));
    chk({tag, "_zero"}, 32'(zero_flag), 32'(v == 0));
    if (v != 0) chk({tag, "_msb"}, 32'(data_out[SW-1]), 32'd1);
  endtask

  initial begin
    int highs;
    int k;
    logic [SW-1:0] d;
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_count", 32'(shift_count), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op("msb_set", 26'h2000000, 1'b0);
    @(negedge clk);
    chk("ready_pulse", 32'(ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    run_op("lsb_only", 26'h0000001, 1'b0);
    run_op("all_zero", 26'h0000000, 1'b0);
    run_op("lz7_poke", 26'h0040000, 1'b1);

    // load during DONE is dropped; DUT must remain idle afterwards
    data_in = 26'h0000010;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("done_load_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_load_busy1", 32'(busy), 32'd0);
    chk("held_count", 32'(shift_count), 32'd7);
    chk("held_data", 32'(data_out), 32'h2000000);

    // Reset in the fifth SHIFT cycle discards the operation
    data_in = 26'h1;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_count", 32'(shift_count), 32'd0);
    chk("mid_rst_zero", 32'(zero_flag), 32'd0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) highs++;
    end
    chk("no_ready_after_rst", 32'(highs), 32'd0);

    // Random sweep with a spread of leading-zero counts
    for (int i = 0; i < 1000; i++) begin
      k = $urandom_range(0, SW);
      d = SW'($urandom) >> k;
      run_op("rand", d, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/norm_lzc_shifter.md
Name: norm_lzc_shifter

Overview:
- Iterative normalisation stage for the FPU mantissa path. It sits directly upstream of the exponent subtractor.
- It left-shifts an unnormalised mantissa until its MSB is 1 and counts the shift positions.
- Shift_Count feeds the subtractor's W-bit B operand, so the result is exponent minus leading-zero count.
- Data_Out feeds the rounding/packing stage.

Parameters:
- SW, 26, mantissa width in bits (hidden bit + fraction + guard/round/sticky); requires SW <= 2**W.
- W, 5, width of Shift_Count; matches the subtractor's B input width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  start request; sampled only in IDLE.
- Data_In  input  SW  unnormalised mantissa.
- busy  output  1  high in SHIFT and DONE.
- ready  output  1  one-cycle pulse; results are valid.
- Data_Out  output  SW  normalised mantissa, held until the next accepted load.
- Shift_Count  output  W  number of left shifts applied, held.
- Zero_Flag  output  1  Data_In was all zeros, held.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, ready=0, Data_Out=0, Shift_Count=0, Zero_Flag=0.
  - Reset wins over every other event, including mid-operation; any partial result is discarded.
- Internal registers: working register M[SW-1:0] and counter C[W-1:0].
- IDLE:
  - If load=1, then M<=Data_In, C<=0, Zero_Flag<=0, and the state goes to SHIFT.
  - Data_Out and Shift_Count keep their previous values until DONE.
- SHIFT, evaluated each cycle, in priority order:
  1. M==0: Zero_Flag<=1, C unchanged (0), state goes to DONE.
  2. M[SW-1]==1: state goes to DONE.
  3. Otherwise: M<=M<<1 (zero fill), C<=C+1, stay in SHIFT.
- DONE, one cycle only:
  - Data_Out<=M and Shift_Count<=C are registered on entry to DONE, so they are visible in the same cycle ready is high.
  - ready=1, busy=1, state goes to IDLE.
- load handling:
  - load is ignored while busy=1; no queueing.
  - load asserted in the DONE cycle is ignored.
  - A new load is accepted on the first IDLE cycle.
- Latency: with L leading zeros (1-bit stepping), SHIFT lasts L+1 cycles. ready is high in cycle L+2 after the cycle in which load was sampled.
- Zero input: SHIFT lasts 1 cycle; Data_Out=0, Shift_Count=0, Zero_Flag=1.
- Width rule: C never exceeds SW-1 because the MSB check terminates first. Since SW <= 2**W, there is no wrap-around.
- Back-to-back throughput: one operation every L+3 cycles minimum.

Optional Feature:
- Macro: NORM_COARSE_STEP_EN.
- Defined: in SHIFT, rule 3 is replaced by:
  - if M[SW-1:SW-4]==0 and M!=0, then M<=M<<4 and C<=C+4;
  - else M<=M<<1 and C<=C+1.
  - Results are bit-identical to the non-macro build.
  - SHIFT length becomes floor(L/4)+(L mod 4)+1 cycles.
- Undefined: 1-bit stepping only; no 4-bit mux is present.

Test Plan:
- Data_In=26'h2000000, load pulse → SHIFT 1 cycle; ready 2 cycles after load; Shift_Count=0, Data_Out=26'h2000000, Zero_Flag=0.
- Data_In=26'h0000001 → Shift_Count=25 (5'h19), Data_Out=26'h2000000.
  - Macro off: ready after 27 cycles.
  - Macro on: SHIFT 8 cycles (6 coarse + 1 fine + check), ready after 9 cycles.
- Data_In=0 → ready after 2 cycles; Zero_Flag=1, Shift_Count=0, Data_Out=0.
- Data_In=26'h0040000 (L=7) → Shift_Count=7, Data_Out=26'h2000000.
  - Then pulse load with Data_In=26'h1 while busy → ignored; outputs remain 7 / 26'h2000000 after ready.
- Start Data_In=26'h1, assert rst at SHIFT cycle 5 → next cycle: IDLE, busy=0, ready=0, all outputs 0; no ready pulse follows.
- Random Data_In sweep (≥1000 vectors, both macro settings) → Data_Out == Data_In << Shift_Count, and Data_Out[SW-1]==1 for every nonzero Data_In.
  - Shift_Count also drives the exponent subtractor: Y == A − Shift_Count (mod 2**P).
